serial_mag_cmp: RTL and testbench

Parametrised bit-serial magnitude comparator. It succeeds the team's 4-bit combinational A>B / A==B comparator. It captures two WIDTH-bit operands on a start pulse and scans them MSB-first, one bit per clock. It stops early at the first differing bit and reports registered greater / equal / less flags with a one-cycle done pulse. It supports unsigned and two's-complement signed comparison, selected per operation, and sits in datapaths where comparator area matters more than latency.

---
 rtl/serial_mag_cmp.sv | 139 +++++++++++++
 tb/tb_serial_mag_cmp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: captures two operands on start, scans MSB-first one bit per
// clock, exits at the first differing bit, and reports registered gt/eq/lt with a done pulse.
module serial_mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic             mode_cap;
  logic [IW-1:0]    idx;

  logic             bit_a;
  logic             bit_b;
  logic             differ;
  logic             at_msb;
  logic             at_lsb;
  logic             accept;
  logic [1:0]       order;

  logic             busy_nxt;
  logic             done_nxt;
  logic             gt_nxt;
  logic             eq_nxt;
  logic             lt_nxt;

  // Returns {gt, lt} for a differing bit pair. At the sign position a set bit marks the
  // negative operand, so the ordering flips; below it equal signs make the rest unsigned.
  function automatic logic [1:0] order_bits(input logic ba, input logic bb, input logic sign_pos);
    if (sign_pos) begin
      order_bits = {bb, ba};
    end else begin
      order_bits = {ba, bb};
    end
  endfunction

  assign accept = (state == IDLE) && start;
  assign bit_a  = a_cap[idx];
  assign bit_b  = b_cap[idx];
  assign differ = bit_a ^ bit_b;
  assign at_msb = (idx == MSB_IDX);
  assign at_lsb = (idx == '0);
  assign order  = order_bits(bit_a, bit_b, mode_cap && at_msb);

  // Operand capture: data registers, loaded only when a request is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      a_cap    <= a;
      b_cap    <= b;
      mode_cap <= signed_mode;
    end
  end

  // State, bit index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      gt    <= gt_nxt;
      eq    <= eq_nxt;
      lt    <= lt_nxt;
      if (accept) begin
        idx <= MSB_IDX;
      end else if (state == SCAN) begin
        idx <= idx - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (differ || at_lsb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    gt_nxt   = gt;
    eq_nxt   = eq;
    lt_nxt   = lt;
    case (state)
      IDLE: busy_nxt = start;
      SCAN: begin
        if (differ) begin
          done_nxt = 1'b1;
          gt_nxt   = order[1];
          lt_nxt   = order[0];
          eq_nxt   = 1'b0;
        end else if (at_lsb) begin
          done_nxt = 1'b1;
          gt_nxt   = 1'b0;
          eq_nxt   = 1'b1;
          lt_nxt   = 1'b0;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  a_flags_onehot : assert property (@(posedge clk) disable iff (rst) done |-> $onehot({gt, eq, lt}));
  a_busy_done_excl : assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Bench for serial_mag_cmp: directed table and corner sequences at WIDTH=4, randomised
// comparison against an arithmetic reference at WIDTH=8.
module tb_serial_mag_cmp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, mode4, busy4, done4, gt4, eq4, lt4;
  logic [3:0] a4, b4;
  logic       start8, mode8, busy8, done8, gt8, eq8, lt8;
  logic [7:0] a8, b8;

  int checks = 0;
  int errors = 0;

  serial_mag_cmp #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  serial_mag_cmp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [2:0] flags;  // {gt, eq, lt}
    int         k;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Issues one WIDTH=4 comparison; poke > 0 re-asserts start with other operands mid-scan.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m, input int poke,
                     output int k, output int bcnt, output logic [2:0] f);
    a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom);
    k = 0;
    bcnt = int'(busy4);
    forever begin
      if (poke != 0 && k == poke) start4 = 1'b1;
      tick();
      start4 = 1'b0;
      k++;
      if (done4) break;
      bcnt += int'(busy4);
      if (k > 12) begin
        checks++; errors++;
        $display("FAIL op4_timeout: got no done after %0d cycles, want done", k);
        break;
      end
    end
    f = {gt4, eq4, lt4};
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     output int k, output logic [2:0] f);
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    k = 0;
    forever begin
      tick();
      k++;
      if (done8) break;
      if (k > 20) begin
        checks++; errors++;
        $display("FAIL op8_timeout: got no done after %0d cycles, want done", k);
        break;
      end
    end
    f = {gt8, eq8, lt8};
  endtask

  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic m);
    int ia, ib;
    ia = m ? int'($signed(a)) : int'(a);
    ib = m ? int'($signed(b)) : int'(b);
    if (ia > ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_k(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    x = a ^ b;
    for (int p = 7; p >= 0; p--) if (x[p]) return 8 - p;
    return 8;
  endfunction

  initial begin
    int k, bc, dcnt;
    logic [2:0] f;
    logic [7:0] ra, rb;
    logic rm;

    vecs[0] = '{4'd9,  4'd9,  1'b0, 3'b010, 4};
    vecs[1] = '{4'd9,  4'd3,  1'b0, 3'b100, 1};
    vecs[2] = '{4'd9,  4'd3,  1'b1, 3'b001, 1};
    vecs[3] = '{4'd5,  4'd4,  1'b0, 3'b100, 4};
    vecs[4] = '{4'd2,  4'd7,  1'b0, 3'b001, 2};
    vecs[5] = '{4'd15, 4'd14, 1'b1, 3'b100, 4};
    vecs[6] = '{4'd8,  4'd7,  1'b1, 3'b001, 1};
    vecs[7] = '{4'd8,  4'd7,  1'b0, 3'b100, 1};
    vecs[8] = '{4'd0,  4'd0,  1'b1, 3'b010, 4};
    vecs[9] = '{4'd6,  4'd5,  1'b0, 3'b100, 3};

    rst = 1'b1;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_dut4", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
    chk("reset_dut8", {27'd0, busy8, done8, gt8, eq8, lt8}, 32'd0);
    tick();

    // Directed table; each operation starts in the done cycle of the previous one
    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].m, 0, k, bc, f);
      chk($sformatf("vec%0d_flags", i), {29'd0, f}, {29'd0, vecs[i].flags});
      chk($sformatf("vec%0d_latency", i), k, vecs[i].k);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].k);
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy4}, 32'd0);
    end

    // Full scan, then flags hold while operands wander and done stays low
    op4(4'd5, 4'd4, 1'b0, 0, k, bc, f);
    chk("hold_first_flags", {29'd0, f}, 32'b100);
    for (int c = 0; c < 10; c++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom);
      tick();
      chk($sformatf("hold_cycle%0d", c), {27'd0, busy4, done4, gt4, eq4, lt4}, 32'b00100);
    end

    // start re-pulsed mid-scan with different operands is ignored
    op4(4'd5, 4'd4, 1'b0, 1, k, bc, f);
    chk("midstart_flags", {29'd0, f}, 32'b100);
    chk("midstart_latency", k, 4);

    // Back-to-back: equal scan, then a new start in its done cycle
    op4(4'd9, 4'd9, 1'b0, 0, k, bc, f);
    chk("b2b_first_flags", {29'd0, f}, 32'b010);
    op4(4'd2, 4'd7, 1'b0, 0, k, bc, f);
    chk("b2b_second_flags", {29'd0, f}, 32'b001);
    chk("b2b_second_latency", k, 2);

    // Reset during the second scan cycle aborts without a done pulse
    a4 = 4'd1; b4 = 4'd0; mode4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      dcnt += int'(done4) + int'(busy4);
    end
    chk("abort_no_done", dcnt, 0);

    // Reset wins over start on the same edge
    rst = 1'b1; start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    tick();
    rst = 1'b0; start4 = 1'b0;
    chk("rst_start_busy", {31'd0, busy4}, 32'd0);
    tick();
    chk("rst_start_idle", {30'd0, busy4, done4}, 32'd0);

    // Randomised WIDTH=8 against the arithmetic reference
    for (int n = 0; n < 2000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 7) == 1) rb = ra ^ (8'd1 << $urandom_range(0, 7));
      rm = 1'($urandom);
      op8(ra, rb, rm, k, f);
      chk($sformatf("rand%0d_flags a=%0h b=%0h m=%0d", n, ra, rb, rm), {29'd0, f},
          {29'd0, ref_flags(ra, rb, rm)});
      chk($sformatf("rand%0d_onehot", n), $countones(f), 1);
      chk($sformatf("rand%0d_latency a=%0h b=%0h", n, ra, rb), k, ref_k(ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
